uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001: Parameter N, default 8: data bits per frame (5..9).
- REQ-002: Parameter CLKS_PER_BIT, default 16: clk_i cycles per bit time (>=2).
- REQ-003: Parameter PARITY_EN, default 0: 1 = parity bit after data.
- REQ-004: Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- REQ-005: Parameter STOP_BITS, default 1: number of stop bits (1 or 2).
- REQ-006: clk_i  input  1  sole clock; all logic on its rising edge.
- REQ-007: rst_i  input  1  reset; synchronous, active-high.
- REQ-008: data_i  input  N  byte to transmit; sampled only on handshake.
- REQ-009: valid_i  input  1  data_i holds a frame to send.
- REQ-010: ready_o  output  1  block can accept a frame this cycle.
- REQ-011: tx_o  output  1  serial line, idle high.
- REQ-012: busy_o  output  1  frame in progress.
- REQ-013: done_o  output  1  one-cycle pulse at frame completion.

Function
- REQ-014: The FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
- REQ-015: Handshake SHALL occur at a rising edge where valid_i=1 and ready_o=1; data_i is latched into the shift register at that edge.
- REQ-016: ready_o SHALL be 1 only in IDLE; busy_o SHALL be 1 in every state except IDLE; ready_o SHALL equal the inverse of busy_o.
- REQ-017: valid_i while ready_o=0 SHALL be ignored and not queued; data_i changes after handshake SHALL not affect the frame in flight.
- REQ-018: Handshake edge SHALL move IDLE->START; tx_o=0 for CLKS_PER_BIT cycles starting the cycle after handshake.
- REQ-019: DATA SHALL drive data bits LSB first, each for exactly CLKS_PER_BIT cycles, N bits total.
- REQ-020: When PARITY_EN=1, PARITY SHALL drive XOR of latched data (even), or its inverse when PARITY_ODD=1, for CLKS_PER_BIT cycles; otherwise DATA->STOP directly.
- REQ-021: STOP SHALL drive tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
- REQ-022: done_o SHALL be 1 for exactly the first IDLE cycle after STOP; ready_o is already 1 in that cycle.
- REQ-023: Frame length from handshake edge to done_o cycle SHALL be CLKS_PER_BIT*(1+N+PARITY_EN+STOP_BITS) cycles.
- REQ-024: Back-to-back frames: valid_i held high SHALL be accepted at the edge ending the done_o cycle, giving exactly one extra idle-high cycle between stop and next start.
- REQ-025: Bit-time counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1 and wrap to 0 on each bit boundary; bit index counter SHALL wrap to 0 on leaving DATA.
- REQ-026: tx_o SHALL be driven from a register, glitch-free, never combinationally from data_i.

Reset
- REQ-027: rst_i=1 at an edge SHALL force IDLE, tx_o=1, ready_o=1, busy_o=0, done_o=0, counters and shift register 0, in the following cycle.
- REQ-028: Reset mid-frame SHALL abandon the frame immediately with no done_o pulse; a handshake coinciding with rst_i SHALL be discarded.
- REQ-029: After rst_i deasserts, the first handshake SHALL be accepted at the next edge with valid_i=1.

Verification (CLKS_PER_BIT=4, N=8 unless stated)
- REQ-030: Reset: rst_i high 2 cycles -> tx_o=1, ready_o=1, busy_o=0, done_o=0.
- REQ-031: Send 0x55, no parity, 1 stop -> tx_o bits 0,1,0,1,0,1,0,1,0,1, each 4 cycles; done_o exactly 40 cycles after handshake.
- REQ-032: PARITY_EN=1, data 0x07 -> parity bit 1 (even), 0 (PARITY_ODD=1); frame 44 cycles; STOP_BITS=2 -> 48 cycles.
- REQ-033: valid_i held with 0xA5 then 0x3C -> second handshake in done_o cycle; exactly one tx_o=1 idle cycle between frames; 0x3C decoded intact.
- REQ-034: rst_i pulsed during data bit 3 -> next cycle tx_o=1, ready_o=1, busy_o=0, no done_o; new frame 0x81 then sent correctly.
- REQ-035: data_i toggled and valid_i pulsed while busy_o=1 -> in-flight frame unchanged, no extra frame emitted.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter with valid/ready intake, optional parity and 1-2 stop bits.
module uart_tx #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic         tx_o,
  output logic         busy_o,
  output logic         done_o
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(N);
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [N-1:0]  shreg;
  logic          tx, done, bit_end;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign ready_o = state == IDLE;
  assign busy_o  = !ready_o;
  assign tx_o    = tx;
  assign done_o  = done;
  // bit_idx walks data bits, then is reused to count stop bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt  <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (valid_i) begin
          state <= START;
          shreg <= data_i;
          tx    <= 1'b0;
        end
        START: if (bit_end) begin
          state <= DATA;
          tx    <= shreg[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx == BW'(N - 1)) begin
            bit_idx <= '0;
            state   <= (PARITY_EN != 0) ? PARITY : STOP;
            tx      <= (PARITY_EN != 0) ? (^shreg) ^ (PARITY_ODD != 0) : 1'b1;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx      <= shreg[bit_idx + 1'b1];
          end
        end
        PARITY: if (bit_end) begin
          state <= STOP;
          tx    <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (bit_idx == BW'(STOP_BITS - 1)) begin
            bit_idx <= '0;
            state   <= IDLE;
            done    <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four uart_tx variants driven in parallel and checked against a frame-level model.
module tb_uart_tx;
  localparam int CPB = 4;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0;
  logic [7:0] data = '0;
  logic [3:0] tx, rdy, bsy, dn;
  int pe[4] = '{0, 1, 1, 1};
  int po[4] = '{0, 0, 1, 0};
  int sb[4] = '{1, 1, 1, 2};
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  uart_tx #(.N(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
    .ready_o(rdy[0]), .tx_o(tx[0]), .busy_o(bsy[0]), .done_o(dn[0]));
  uart_tx #(.N(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
    .ready_o(rdy[1]), .tx_o(tx[1]), .busy_o(bsy[1]), .done_o(dn[1]));
  uart_tx #(.N(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
    .ready_o(rdy[2]), .tx_o(tx[2]), .busy_o(bsy[2]), .done_o(dn[2]));
  uart_tx #(.N(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
    .ready_o(rdy[3]), .tx_o(tx[3]), .busy_o(bsy[3]), .done_o(dn[3]));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // line level j cycles after the handshake edge, from the frame's bit list
  function automatic logic model_bit(input int u, input logic [7:0] d, input int j);
    bit q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pe[u] != 0) q.push_back((^d) ^ po[u][0]);
    for (int i = 0; i < sb[u]; i++) q.push_back(1'b1);
    return (j / CPB < q.size()) ? q[j / CPB] : 1'b1;
  endfunction

  function automatic int frame_len(input int u);
    return CPB * (1 + 8 + pe[u] + sb[u]);
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (rdy !== 4'hF && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rdy !== 4'hF) check("idle_timeout", rdy, 4'hF);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit disturb);
    logic [127:0] obs[4];
    logic [127:0] exp;
    int dj[4], nd[4];
    logic [3:0] rd_at_done;
    wait_idle();
    data = d;
    valid = 1'b1;
    for (int u = 0; u < 4; u++) begin
      obs[u] = '0; dj[u] = -1; nd[u] = 0;
    end
    rd_at_done = '0;
    for (int j = 0; j < 56; j++) begin
      @(negedge clk);
      if (j == 0) begin
        valid = 1'b0;
        check({tag, "_busy"}, bsy, 4'hF);
      end
      if (disturb) begin
        data = 8'($urandom);
        valid = (j == 10 || j == 20 || j == 30);
      end
      for (int u = 0; u < 4; u++) begin
        obs[u][j] = tx[u];
        if (dn[u]) begin
          nd[u]++;
          if (dj[u] < 0) begin
            dj[u] = j;
            rd_at_done[u] = rdy[u];
          end
        end
      end
    end
    valid = 1'b0;
    for (int u = 0; u < 4; u++) begin
      exp = '0;
      for (int j = 0; j < 56; j++) exp[j] = model_bit(u, d, j);
      check($sformatf("%s_tx%0d", tag, u), obs[u], exp);
      check($sformatf("%s_done_at%0d", tag, u), dj[u], frame_len(u));
      check($sformatf("%s_done_n%0d", tag, u), nd[u], 1);
    end
    check({tag, "_ready_at_done"}, rd_at_done, 4'hF);
  endtask

  initial begin
    logic [127:0] obs0, exp0;
    int nd, d1, d2, nlow;
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 4'hF);
    check("rst_ready", rdy, 4'hF);
    check("rst_busy", bsy, 4'h0);
    check("rst_done", dn, 4'h0);
    rst = 1'b0;
    run_frame("x55", 8'h55, 1'b0);
    run_frame("x07", 8'h07, 1'b0);
    for (int i = 0; i < 6; i++)
      run_frame($sformatf("rnd%0d", i), 8'($urandom), i[0]);
    // back-to-back with valid held: second byte taken at the edge ending done_o
    wait_idle();
    data = 8'hA5;
    valid = 1'b1;
    obs0 = '0; nd = 0; d1 = -1; d2 = -1;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (j == 0) data = 8'h3C;
      if (j == 45) valid = 1'b0;
      obs0[j] = tx[0];
      if (dn[0]) begin
        nd++;
        if (d1 < 0) d1 = j; else if (d2 < 0) d2 = j;
      end
    end
    exp0 = '0;
    for (int j = 0; j < 100; j++)
      exp0[j] = (j < 41) ? model_bit(0, 8'hA5, j) : model_bit(0, 8'h3C, j - 41);
    check("b2b_tx", obs0, exp0);
    check("b2b_done1", d1, 40);
    check("b2b_done2", d2, 81);
    check("b2b_done_n", nd, 2);
    // reset during data bit 3, with a coinciding handshake attempt
    wait_idle();
    data = 8'h5A;
    valid = 1'b1;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      if (j == 0) valid = 1'b0;
      if (j == 17) begin
        rst = 1'b1; valid = 1'b1; data = 8'hFF;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    check("mid_rst_tx", tx, 4'hF);
    check("mid_rst_ready", rdy, 4'hF);
    check("mid_rst_busy", bsy, 4'h0);
    check("mid_rst_done", dn, 4'h0);
    nd = 0; nlow = 0;
    repeat (60) begin
      @(negedge clk);
      if (dn != 0) nd++;
      if (tx != 4'hF) nlow++;
    end
    check("mid_rst_no_done", nd, 0);
    check("mid_rst_line_idle", nlow, 0);
    run_frame("x81", 8'h81, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
